// File: rtl/hazard_unit.sv
// hazard_unit: pipeline advance/stall/flush control ahead of the forwarding
// unit. Resolves halt, data-cache wait, branch flush, load-use bubble and
// instruction-fetch wait, remembers a fetch that landed while the PC was held,
// and keeps saturating debug counters of stall cycles and branch flushes.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_regRd,
  input  logic [4:0]       id_regRs,
  input  logic [4:0]       id_regRt,
  input  logic             id_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_ifetch_done;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_mem_block;
  logic w_fetch_ok;
  logic w_load_use;
  logic w_flush_evt;
  logic w_stall_evt;

  assign w_mem_block = (mem_dREN | mem_dWEN) & ~dhit;
  assign w_fetch_ok  = ihit | r_ifetch_done;
  assign w_load_use  = ex_dREN & (ex_regRd != 5'd0) &
                       ((ex_regRd == id_regRs) | (id_uses_rt & (ex_regRd == id_regRt)));

  // A PC-held cycle counts as a stall only while the core is still live.
  assign w_stall_evt = ~pc_en & (r_state != ST_HALTED);

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

  // Priority decode of latch enables/flushes and next state.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    halted       = 1'b0;
    w_flush_evt  = 1'b0;
    w_state_next = r_state;
    if (!nRST) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN, ST_MEMWAIT: begin
          if (wb_halt) begin
            w_state_next = ST_HALTED;
          end else if (w_mem_block) begin
            w_state_next = ST_MEMWAIT;
          end else begin
            // Access done (or none pending): one advance cycle, back to RUN.
            w_state_next = ST_RUN;
            exmem_en     = 1'b1;
            memwb_en     = 1'b1;
            idex_en      = 1'b1;
            if (ex_branch_taken) begin
              pc_en       = 1'b1;
              ifid_en     = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              w_flush_evt = 1'b1;
            end else if (w_load_use) begin
              idex_flush  = 1'b1;
            end else if (!w_fetch_ok) begin
              ifid_en     = 1'b1;
              ifid_flush  = 1'b1;
            end else begin
              pc_en       = 1'b1;
              ifid_en     = 1'b1;
            end
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Remember a fetch that completed while the PC was held; clear wins on advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ifetch_done <= 1'b0;
    end else if (pc_en) begin
      r_ifetch_done <= 1'b0;
    end else if (ihit) begin
      r_ifetch_done <= 1'b1;
    end else begin
      r_ifetch_done <= r_ifetch_done;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cycles <= {CNT_W{1'b0}};
    end else if (w_stall_evt && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  // Saturating branch-flush counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_flush_count <= {CNT_W{1'b0}};
    end else if (w_flush_evt && (r_flush_count != CNT_MAX)) begin
      r_flush_count <= r_flush_count + CNT_ONE;
    end else begin
      r_flush_count <= r_flush_count;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic against a behavioural model that only tracks "halted", the pending
// fetch flag and two integer counters.
module tb_hazard_unit;

  localparam int CNT_W   = 16;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
  logic [4:0]       ex_regRd, id_regRs, id_regRt;
  logic             id_uses_rt, ex_branch_taken, wb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_halted;
  bit m_ifd;
  int m_stall;
  int m_flush;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
    .ex_regRd(ex_regRd), .id_regRs(id_regRs), .id_regRt(id_regRt),
    .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  endfunction

  // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush} from the rules.
  function automatic logic [6:0] model_outs();
    bit mem_block, fetch_ok, load_use;
    mem_block = (mem_dREN || mem_dWEN) && !dhit;
    fetch_ok  = ihit || m_ifd;
    load_use  = ex_dREN && ex_regRd != 0 &&
                (ex_regRd == id_regRs || (id_uses_rt && ex_regRd == id_regRt));
    if (!nRST || m_halted || wb_halt || mem_block) return 7'b0000000;
    if (ex_branch_taken) return 7'b1111111;
    if (load_use)        return 7'b0011101;
    if (!fetch_ok)       return 7'b0111110;
    return 7'b1111100;
  endfunction

  task automatic clear_inputs();
    ihit = 1'b0; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
    ex_regRd = 5'd0; id_regRs = 5'd0; id_regRt = 5'd0; id_uses_rt = 1'b0;
    ex_branch_taken = 1'b0; wb_halt = 1'b0;
  endtask

  // Inputs are set just after a negedge; check, advance model, wait next negedge.
  task automatic cycle();
    logic [6:0] exp_o;
    bit mem_block;
    #1;
    if (!nRST) begin
      m_halted = 1'b0; m_ifd = 1'b0; m_stall = 0; m_flush = 0;
    end
    exp_o = model_outs();
    check_val("outs", {25'd0, dut_outs()}, {25'd0, exp_o});
    check_val("halted", {31'd0, halted}, {31'd0, m_halted});
    check_val("stall", {16'd0, stall_cycles}, m_stall);
    check_val("flush", {16'd0, flush_count}, m_flush);
    if (nRST && !m_halted) begin
      mem_block = (mem_dREN || mem_dWEN) && !dhit;
      if (!exp_o[6] && m_stall < CNT_SAT) m_stall++;
      if (!wb_halt && !mem_block && ex_branch_taken && m_flush < CNT_SAT) m_flush++;
      if (exp_o[6]) m_ifd = 1'b0;
      else if (ihit) m_ifd = 1'b1;
      if (wb_halt) m_halted = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    m_halted = 1'b0; m_ifd = 1'b0; m_stall = 0; m_flush = 0;
    @(negedge CLK);

    // reset state
    cycle();
    check_val("rst_outs", {25'd0, dut_outs()}, 32'd0);
    nRST = 1'b1;

    // no hazards
    ihit = 1'b1;
    cycle();
    check_val("idle_outs", {25'd0, dut_outs()}, 32'h7C);
    check_val("idle_stall", {16'd0, stall_cycles}, 32'd0);

    // load-use bubble
    ex_dREN = 1'b1; ex_regRd = 5'd5; id_regRs = 5'd5;
    #1 check_val("lu_outs", {25'd0, dut_outs()}, 32'h1D);
    cycle();
    ex_regRd = 5'd0;
    #1 check_val("lu_stall_next", {16'd0, stall_cycles}, 32'd1);
    check_val("lu_r0_outs", {25'd0, dut_outs()}, 32'h7C);
    cycle();
    clear_inputs();

    // data-cache wait: three frozen cycles, fetch lands in cycle 2
    mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ihit = (i == 1);
      #1 check_val("mw_frozen", {25'd0, dut_outs()}, 32'd0);
      cycle();
    end
    ihit = 1'b0; dhit = 1'b1;
    #1 check_val("mw_release", {25'd0, dut_outs()}, 32'h7C);
    cycle();
    clear_inputs();
    ihit = 1'b1;
    cycle();

    // branch outranks load-use and missing fetch
    do_reset();
    ex_branch_taken = 1'b1; ex_dREN = 1'b1; ex_regRd = 5'd5; id_regRs = 5'd5; ihit = 1'b0;
    #1 check_val("br_outs", {25'd0, dut_outs()}, 32'h7F);
    cycle();
    clear_inputs();
    #1 check_val("br_count", {16'd0, flush_count}, 32'd1);
    cycle();

    // halt beside a pending data access, then hold with random inputs
    wb_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      {ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, id_uses_rt, ex_branch_taken, wb_halt} = 8'($urandom);
      ex_regRd = 5'($urandom); id_regRs = 5'($urandom); id_regRt = 5'($urandom);
      #1 check_val("halt_hold", {31'd0, halted}, 32'd1);
      cycle();
    end
    nRST = 1'b0;
    #1 check_val("halt_rst", {31'd0, halted}, 32'd0);
    check_val("halt_rst_stall", {16'd0, stall_cycles}, 32'd0);
    cycle();
    nRST = 1'b1;
    clear_inputs();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      nRST            = ($urandom_range(0, 299) != 0);
      ihit            = ($urandom_range(0, 3) != 0);
      dhit            = ($urandom_range(0, 2) != 0);
      mem_dREN        = ($urandom_range(0, 4) == 0);
      mem_dWEN        = ($urandom_range(0, 6) == 0);
      ex_dREN         = ($urandom_range(0, 2) == 0);
      ex_regRd        = 5'($urandom_range(0, 3));
      id_regRs        = 5'($urandom_range(0, 3));
      id_regRt        = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      wb_halt         = ($urandom_range(0, 199) == 0);
      cycle();
    end

    // stall counter saturation
    do_reset();
    ihit = 1'b1; ex_dREN = 1'b1; ex_regRd = 5'd7; id_regRs = 5'd7;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle();
    clear_inputs();
    #1 check_val("stall_sat", {16'd0, stall_cycles}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control stage directly upstream of the forwarding unit.
- Decides each cycle which pipeline latches advance, stall or flush, so that forwarding sees a legal EX/MEM/WB population: load-use bubble, branch/jump flush, cache-wait freeze and halt.
- Also holds a fetched-instruction flag across memory waits and keeps saturating stall/flush counters for debug.

Parameters:
- CNT_W, 16, width of the stall_cycles and flush_count counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache returns the instruction this cycle.
- dhit  in  1  dcache completes the MEM-stage access this cycle.
- mem_dREN  in  1  MEM-stage instruction is a load.
- mem_dWEN  in  1  MEM-stage instruction is a store.
- ex_dREN  in  1  EX-stage instruction is a load.
- ex_regRd  in  5  EX-stage destination register.
- id_regRs  in  5  ID-stage rs.
- id_regRt  in  5  ID-stage rt.
- id_uses_rt  in  1  ID instruction reads rt (R-type, branch, store).
- ex_branch_taken  in  1  EX resolved a taken branch, jump, JR or JAL.
- wb_halt  in  1  HALT instruction is in WB.
- pc_en  out  1  PC loads its next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush  out  1 each  load a bubble on enable.
- halted  out  1  core halted, sticky.
- stall_cycles  out  CNT_W  cycles with pc_en=0 while not halted.
- flush_count  out  CNT_W  branch flushes.

Behaviour:
- States: RUN, MEMWAIT, HALTED.
- Outputs are combinational from state and inputs. nRST low forces state=RUN, ifetch_done=0 and counters=0.
- While nRST is low, all enables and flushes are 0 and halted=0. Reset mid-operation returns to RUN immediately.
- mem_block = (mem_dREN|mem_dWEN) & ~dhit.
- fetch_ok = ihit | ifetch_done.
- load_use = ex_dREN & ex_regRd!=0 & (ex_regRd==id_regRs | (id_uses_rt & ex_regRd==id_regRt)).
- Priority in RUN/MEMWAIT, highest first:
  1. wb_halt: all en=0; next HALTED.
  2. mem_block: all en=0, flushes=0; next MEMWAIT.
  3. ex_branch_taken: all en=1, ifid_flush=1, idex_flush=1, pc_en=1 regardless of fetch_ok; flush_count++.
  4. load_use: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=memwb_en=1.
  5. ~fetch_ok: pc_en=0; ifid_en=1 with ifid_flush=1; idex_en=exmem_en=memwb_en=1.
  6. Otherwise: all en=1, no flush.
- In MEMWAIT, dhit makes mem_block=0, so the same-cycle outputs follow rules 3-6 and the next state is RUN. That gives one advance cycle per completed access.
- ifetch_done:
  - Set on ihit & ~pc_en (fetch completed while PC held, e.g. during MEMWAIT or load-use).
  - Cleared when pc_en=1.
  - Set and clear in the same cycle: clear wins.
- HALTED: all en=0, flushes=0, halted=1. Only nRST exits.
- stall_cycles increments when pc_en=0 and state!=HALTED. flush_count increments on rule 3. Both saturate at all-ones.
- A load in MEM with dhit=1 in its first cycle never enters MEMWAIT.

Test Plan:
- Reset, then ihit=1, no hazards -> all enables 1, no flushes, state RUN, counters 0.
- ex_dREN=1, ex_regRd=5, id_regRs=5 -> pc_en=0, ifid_en=0, idex_flush=1, stall_cycles=1 next cycle. Repeat with ex_regRd=0 -> no stall.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1:
  - 3 frozen cycles, then one all-enable cycle, then RUN.
  - Drive ihit=1 only in cycle 2: ifid advances without a flush on the dhit cycle (ifetch_done used).
- ex_branch_taken=1 with load_use=1 and ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1, flush_count=1.
- wb_halt=1 alongside mem_block=1 -> HALTED, halted=1 held for 10 cycles with any inputs; nRST pulse -> RUN, halted=0, counters 0.
- Force 2^CNT_W+3 load-use stall cycles -> stall_cycles holds 0xFFFF.
